uart_cfg_regbank: RTL
=====================

// Module: uart_cfg_regbank
// PURPOSE
//  Multi-channel UART configuration register bank; successor to the single-channel regfile.
//  Host side: one write port plus two independent read ports (A/B).
//  Each of N_CH UART channels gets its own control slice.
//  Each slice has CTRL, shadowed RATE, sticky STATUS and one reserved register.
//  Per-channel config outputs drive the UART cores. Per-channel status inputs return from them.
// PARAMETERS
//  DATA_WIDTH    16       host data width, must be >= 16
//  N_CH          2        number of UART channels, 1..8
//  ADDR_WIDTH    3        host address width, must be >= $clog2(N_CH)+2
//  READ_LATENCY  0        0 = combinational read, 1 = registered read
//  RST_RATE      16'd9600 reset value of both shadow and active RATE
// PORTS
//  clk          in   1             clock, all logic on rising edge
//  rst          in   1             synchronous reset, active-high
//  wr_en        in   1             write strobe
//  wr_addr      in   ADDR_WIDTH    {channel, reg[1:0]}
//  wr_data      in   DATA_WIDTH    write data
//  wr_err       out  1             1-cycle pulse: write rejected (OOB, reserved, or CTRL while busy)
//  rd_addr_a/b  in   ADDR_WIDTH    read addresses
//  rd_data_a/b  out  DATA_WIDTH    read data
//  rd_valid_a/b out  1             read address in range (aligned with rd_data)
//  uart_busy    in   N_CH          per-channel busy
//  uart_error   in   N_CH          per-channel error event, level sampled each cycle
//  update_ok    in   N_CH          per-channel "safe to apply new rate"
//  uart_enable  out  N_CH          CTRL[0] per channel
//  uart_mode    out  3*N_CH        CTRL[3:1] per channel, channel c at [3c+2:3c]
//  uart_rate    out  16*N_CH       active (committed) rate per channel
//  commit_pulse out  N_CH          1-cycle pulse when shadow RATE is copied to active
// BEHAVIOUR
//  Address map: ch = addr[ADDR_WIDTH-1:2], reg = addr[1:0]. An address >= 4*N_CH is OOB.
//  Registers: 0 CTRL (RW, bits [3:0], upper bits read 0).
//    1 RATE (RW shadow).
//    2 STATUS (bit0 busy RO, bit1 sticky err W1C, bit2 pending RO).
//    3 RESERVED (reads 0, writes rejected).
//  Reset: CTRL=0; shadow RATE = active RATE = RST_RATE; sticky err=0; pending=0.
//    All outputs 0 except uart_rate=RST_RATE; registered rd_data=0; rd_valid=0.
//  Writes: take effect at the rising edge where wr_en=1.
//    OOB or RESERVED write: no state change; wr_err=1 the next cycle.
//    CTRL write while uart_busy[ch]=1: rejected with wr_err; CTRL keeps its old value.
//  RATE write: updates the shadow and sets pending; the active rate is unchanged.
//  Commit: in any cycle with pending & update_ok[ch] & !uart_busy[ch]:
//    active <= shadow, pending <= 0, commit_pulse[ch]=1 the next cycle.
//  A RATE write in the same cycle as a commit: the commit uses the old shadow.
//    The new shadow is stored and pending stays 1.
//  Sticky err: set by uart_error[ch]=1. Cleared by a STATUS write with wr_data[1]=1.
//    Set wins when set and clear occur in the same cycle.
//  Read, READ_LATENCY=0: rd_data is combinational from rd_addr.
//    RAW bypass: same-cycle accepted write to the same address returns wr_data.
//    For STATUS the bypass does not apply; the value is the pre-edge status.
//  Read, READ_LATENCY=1: rd_data/rd_valid are registered, one cycle after the address.
//    Write-first: the read observes the value written at that same edge.
//  OOB read: rd_data=0, rd_valid=0. RESERVED read: rd_data=0, rd_valid=1.
//  Reading RATE returns the shadow. The active rate is visible only on uart_rate.
//  Ports A and B are fully independent; both may address the same register.
//  Reset mid-operation: pending commits are dropped; the active rate returns to RST_RATE.
// STRUCTURE
//  uart_cfg_pkg holds:
//    register offsets REG_CTRL/REG_RATE/REG_STATUS/REG_RSVD;
//    STATUS bit indices;
//    CTRL field positions;
//    typedef ctrl_t (packed: mode[2:0], enable).
//  Sub-module uart_cfg_channel: one channel slice (CTRL, shadow/active rate, pending, sticky err).
//    Generated N_CH times.
//  Top level: address decode, wr_err, read muxes A/B, and the latency pipeline.
// TESTING
//  1. Reset with rst=1 for 3 cycles, then read all 4*N_CH addresses.
//     -> CTRL=0, RATE=9600, STATUS=0, RSVD=0; uart_rate=9600 on every channel.
//  2. Write ch1 RATE=4800 with busy1=1, update_ok1=1.
//     -> uart_rate[31:16] stays 9600 and STATUS1.pending=1.
//     Drop busy1 -> commit_pulse[1] one cycle later; rate becomes 4800 and pending=0.
//  3. Pulse uart_error0 for 1 cycle -> STATUS0 reads 0x2 until a write of 0x2 to STATUS0.
//     Clear and error in the same cycle -> bit stays 1.
//  4. Write addr 4*N_CH (OOB) -> wr_err pulse; reading it gives rd_valid=0, data 0.
//     Write RSVD 0xABCD -> wr_err; reading it gives 0 with rd_valid=1.
//  5. READ_LATENCY=0: wr_en=1, wr_addr=rd_addr_a=ch0 CTRL, data 0x7 -> rd_data_a=0x7 the same cycle.
//     READ_LATENCY=1: the read a cycle later returns 0x7.
//  6. CTRL write 0x5 while busy0=1 -> wr_err; uart_enable[0]/uart_mode unchanged.
//     Retry with busy0=0 -> enable=1, mode=2.

Source files
------------

// File: rtl/uart_cfg_pkg.sv
// Shared register map, STATUS bit positions and CTRL layout for the UART config bank.
// No logic here, so latency and backpressure do not apply.
package uart_cfg_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_RATE   = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    localparam int STAT_BUSY = 0;
    localparam int STAT_ERR  = 1;
    localparam int STAT_PEND = 2;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_W   = 3;
    localparam int CTRL_W        = CTRL_MODE_LSB + CTRL_MODE_W;

    localparam int RATE_W = 16;

    typedef struct packed {
        logic [CTRL_MODE_W-1:0] mode;
        logic                   enable;
    } ctrl_t;

endpackage

// File: rtl/uart_cfg_channel.sv
// One channel slice: CTRL, shadow/active rate with commit handshake, pending flag, sticky error.
// State updates on the write edge; commit_pulse one cycle after commit; no backpressure.
module uart_cfg_channel
    import uart_cfg_pkg::*;
#(
    parameter logic [RATE_W-1:0] RST_RATE = 16'd9600
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ctrl_we,
    input  ctrl_t             ctrl_wdata,
    input  logic              rate_we,
    input  logic [RATE_W-1:0] rate_wdata,
    input  logic              err_clr,
    input  logic              uart_busy,
    input  logic              uart_error,
    input  logic              update_ok,
    output ctrl_t             ctrl_q,
    output ctrl_t             ctrl_n,
    output logic [RATE_W-1:0] shadow_n,
    output logic [RATE_W-1:0] active_q,
    output logic              pending_q,
    output logic              pending_n,
    output logic              err_q,
    output logic              err_n,
    output logic              commit_pulse
);

    logic [RATE_W-1:0] shadow_q;
    logic              commit_now;

    assign commit_now = pending_q & update_ok & ~uart_busy;

    // Next-state values are exported so the top can serve write-through reads.
    // A same-edge RATE write keeps pending set even while the old shadow commits.
    always_comb begin
        ctrl_n    = ctrl_we ? ctrl_wdata : ctrl_q;
        shadow_n  = rate_we ? rate_wdata : shadow_q;
        pending_n = rate_we | (pending_q & ~commit_now);
        err_n     = uart_error | (err_q & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q       <= '0;
            shadow_q     <= RST_RATE;
            active_q     <= RST_RATE;
            pending_q    <= 1'b0;
            err_q        <= 1'b0;
            commit_pulse <= 1'b0;
        end else begin
            ctrl_q       <= ctrl_n;
            shadow_q     <= shadow_n;
            pending_q    <= pending_n;
            err_q        <= err_n;
            commit_pulse <= commit_now;
            if (commit_now) begin
                active_q <= shadow_q;
            end
        end
    end

endmodule

// File: rtl/uart_cfg_regbank.sv
// Multi-channel UART config bank: write decode, wr_err, two independent read ports.
// Read latency 0 (bypassed) or 1 (registered, write-first); writes never stall.
module uart_cfg_regbank
    import uart_cfg_pkg::*;
#(
    parameter int                DATA_WIDTH   = 16,
    parameter int                N_CH         = 2,
    parameter int                ADDR_WIDTH   = 3,
    parameter int                READ_LATENCY = 0,
    parameter logic [RATE_W-1:0] RST_RATE     = 16'd9600
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [ADDR_WIDTH-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    output logic                   wr_err,
    input  logic [ADDR_WIDTH-1:0]  rd_addr_a,
    input  logic [ADDR_WIDTH-1:0]  rd_addr_b,
    output logic [DATA_WIDTH-1:0]  rd_data_a,
    output logic [DATA_WIDTH-1:0]  rd_data_b,
    output logic                   rd_valid_a,
    output logic                   rd_valid_b,
    input  logic [N_CH-1:0]        uart_busy,
    input  logic [N_CH-1:0]        uart_error,
    input  logic [N_CH-1:0]        update_ok,
    output logic [N_CH-1:0]        uart_enable,
    output logic [3*N_CH-1:0]      uart_mode,
    output logic [16*N_CH-1:0]     uart_rate,
    output logic [N_CH-1:0]        commit_pulse
);

    localparam int          CH_W     = (ADDR_WIDTH > 2) ? ADDR_WIDTH - 2 : 1;
    localparam int unsigned ADDR_LIM = 4 * N_CH;

    ctrl_t             ctrl_q   [N_CH];
    ctrl_t             ctrl_n   [N_CH];
    logic [RATE_W-1:0] shadow_n [N_CH];
    logic [RATE_W-1:0] active_q [N_CH];
    logic [N_CH-1:0]   pending_q, pending_n, err_q, err_n;
    logic [N_CH-1:0]   ctrl_we, rate_we, err_clr;
    logic              wr_reject;
    logic [CH_W-1:0]   wr_ch;
    logic [1:0]        wr_reg;
    logic              wr_oob;

    assign wr_ch  = CH_W'(wr_addr >> 2);
    assign wr_reg = wr_addr[1:0];
    assign wr_oob = 32'(wr_addr) >= ADDR_LIM;

    always_comb begin
        ctrl_we   = '0;
        rate_we   = '0;
        err_clr   = '0;
        wr_reject = 1'b0;
        if (wr_en) begin
            if (wr_oob || wr_reg == REG_RSVD) begin
                wr_reject = 1'b1;
            end else begin
                for (int c = 0; c < N_CH; c++) begin
                    if (wr_ch == CH_W'(c)) begin
                        case (wr_reg)
                            REG_CTRL: begin
                                // CTRL is frozen while the core is mid-frame
                                if (uart_busy[c]) wr_reject = 1'b1;
                                else              ctrl_we[c] = 1'b1;
                            end
                            REG_RATE:   rate_we[c] = 1'b1;
                            REG_STATUS: err_clr[c] = wr_data[STAT_ERR];
                            default:    ;
                        endcase
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) wr_err <= 1'b0;
        else     wr_err <= wr_reject;
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        uart_cfg_channel #(.RST_RATE(RST_RATE)) u_ch (
            .clk          (clk),
            .rst          (rst),
            .ctrl_we      (ctrl_we[c]),
            .ctrl_wdata   (ctrl_t'(wr_data[CTRL_W-1:0])),
            .rate_we      (rate_we[c]),
            .rate_wdata   (wr_data[RATE_W-1:0]),
            .err_clr      (err_clr[c]),
            .uart_busy    (uart_busy[c]),
            .uart_error   (uart_error[c]),
            .update_ok    (update_ok[c]),
            .ctrl_q       (ctrl_q[c]),
            .ctrl_n       (ctrl_n[c]),
            .shadow_n     (shadow_n[c]),
            .active_q     (active_q[c]),
            .pending_q    (pending_q[c]),
            .pending_n    (pending_n[c]),
            .err_q        (err_q[c]),
            .err_n        (err_n[c]),
            .commit_pulse (commit_pulse[c])
        );
        assign uart_enable[c]       = ctrl_q[c].enable;
        assign uart_mode[3*c +: 3]  = ctrl_q[c].mode;
        assign uart_rate[16*c +: 16] = active_q[c];
    end

    logic [ADDR_WIDTH-1:0] rd_addr [2];
    logic [DATA_WIDTH-1:0] rd_val  [2];
    logic                  rd_in   [2];

    assign rd_addr[0] = rd_addr_a;
    assign rd_addr[1] = rd_addr_b;

    // CTRL/RATE always read their next-state value: that is the RAW bypass at
    // latency 0 and write-first at latency 1. STATUS reads pre-edge at latency 0.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_val[p] = '0;
            rd_in[p]  = 1'b0;
            if (32'(rd_addr[p]) < ADDR_LIM) begin
                rd_in[p] = 1'b1;
                for (int c = 0; c < N_CH; c++) begin
                    if (CH_W'(rd_addr[p] >> 2) == CH_W'(c)) begin
                        case (rd_addr[p][1:0])
                            REG_CTRL: rd_val[p][CTRL_W-1:0] = ctrl_n[c];
                            REG_RATE: rd_val[p][RATE_W-1:0] = shadow_n[c];
                            REG_STATUS: begin
                                rd_val[p][STAT_BUSY] = uart_busy[c];
                                if (READ_LATENCY == 0) begin
                                    rd_val[p][STAT_ERR]  = err_q[c];
                                    rd_val[p][STAT_PEND] = pending_q[c];
                                end else begin
                                    rd_val[p][STAT_ERR]  = err_n[c];
                                    rd_val[p][STAT_PEND] = pending_n[c];
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    if (READ_LATENCY == 0) begin : g_rd_comb
        assign rd_data_a  = rd_val[0];
        assign rd_data_b  = rd_val[1];
        assign rd_valid_a = rd_in[0];
        assign rd_valid_b = rd_in[1];
    end else begin : g_rd_reg
        always_ff @(posedge clk) begin
            if (rst) begin
                rd_data_a  <= '0;
                rd_data_b  <= '0;
                rd_valid_a <= 1'b0;
                rd_valid_b <= 1'b0;
            end else begin
                rd_data_a  <= rd_val[0];
                rd_data_b  <= rd_val[1];
                rd_valid_a <= rd_in[0];
                rd_valid_b <= rd_in[1];
            end
        end
    end

endmodule
